// File: rtl/data_sram_responder.sv
// Data-RAM responder: accepts one read/byte-masked write at a time, completes after LATENCY cycles.
// Latency LATENCY cycles accept->data_ok; addr_ok drops while a request waits, data_ok has no backpressure.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("data_sram_responder: LATENCY must be in 1..15");
        end
    endgenerate

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam state_t ACCEPT_STATE = (LATENCY == 1) ? S_RESP : S_WAIT;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             resp_q, resp_d;
    logic [31:0]             mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    accept;
    logic                    unused_addr;

    assign idx         = addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

    // addr_ok depends only on state (and reset), never on req
    assign addr_ok = reset && (state_q != S_WAIT);
    assign accept  = req && addr_ok;
    assign data_ok = (state_q == S_RESP);
    assign rdata   = (state_q == S_RESP) ? resp_q : 32'h0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_d = ACCEPT_STATE;
                    cnt_d   = 4'(LATENCY - 1);
                    resp_d  = wr ? 32'h0 : mem[idx];
                end else if (state_q == S_RESP) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            resp_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    // Storage is deliberately not reset; writes commit at their own acceptance edge
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench: one instance at LATENCY=1, one at LATENCY=4, shared clock/reset, queue scoreboard per instance.
module tb_data_sram_responder;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req     [2];
    logic        wr      [2];
    logic [3:0]  wstrb   [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic        addr_ok [2];
    logic        data_ok [2];
    logic [31:0] rdata   [2];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst_n), .req(req[0]), .wr(wr[0]), .wstrb(wstrb[0]),
        .addr(addr[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]),
        .data_ok(data_ok[0]), .rdata(rdata[0])
    );

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_lat4 (
        .clk(clk), .reset(rst_n), .req(req[1]), .wr(wr[1]), .wstrb(wstrb[1]),
        .addr(addr[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]),
        .data_ok(data_ok[1]), .rdata(rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int c, input logic [31:0] dat);
        exp_t e;
        e.cyc = c;
        e.dat = dat;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic do_req(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          input logic [31:0] exp_dat);
        int n = 0;
        req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; wstrb[d] = st;
        while (!addr_ok[d] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!addr_ok[d]) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: dut %0d addr 0x%08h never accepted", d, a);
        end else begin
            push(d, cyc + ((d == 0) ? 1 : 4), exp_dat);
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (data_ok[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL unexpected_data_ok: dut %0d cycle %0d rdata 0x%08h, expected no completion",
                         d, cyc, rdata[d]);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rdata_dut%0d", d), rdata[d], e.dat);
                chk($sformatf("done_cycle_dut%0d", d), cyc, e.cyc);
            end
        end else begin
            chk($sformatf("rdata_idle_dut%0d", d), rdata[d], 32'h0);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wr[d] = 1'b0; wstrb[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
        end
        #3;
        chk("rst_addr_ok_l1", 32'(addr_ok[0]), 32'h0);
        chk("rst_addr_ok_l4", 32'(addr_ok[1]), 32'h0);
        chk("rst_data_ok_l1", 32'(data_ok[0]), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_addr_ok_l1", 32'(addr_ok[0]), 32'h1);
        chk("post_rst_addr_ok_l4", 32'(addr_ok[1]), 32'h1);
        tick(1);

        // LATENCY=1: full write/readback, byte mask, no-op write, aliasing
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
        do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0);
        do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD);
        do_req(0, 1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
        do_req(0, 1'b1, 32'h0, 32'h1, 4'hF, 32'h0);
        do_req(0, 1'b1, 32'h4, 32'h2, 4'hF, 32'h0);
        do_req(0, 1'b1, 32'h8, 32'h3, 4'hF, 32'h0);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1);
        do_req(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'h2);
        do_req(0, 1'b0, 32'h8, 32'h0, 4'h0, 32'h3);
        do_req(0, 1'b1, 32'h1003, 32'h55AA55AA, 4'hF, 32'h0);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h55AA55AA);
        do_req(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'h2);
        tick(2);

        // LATENCY=4: addr_ok profile and back-to-back from RESP
        do_req(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0);
        tick(4);
        do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D);
        chk("wait_addr_ok_1", 32'(addr_ok[1]), 32'h0);
        tick(1);
        chk("wait_addr_ok_2", 32'(addr_ok[1]), 32'h0);
        tick(1);
        chk("wait_addr_ok_3", 32'(addr_ok[1]), 32'h0);
        tick(1);
        chk("resp_addr_ok", 32'(addr_ok[1]), 32'h1);
        chk("resp_data_ok", 32'(data_ok[1]), 32'h1);
        do_req(1, 1'b0, 32'h1040, 32'h0, 4'h0, 32'hCAFEF00D);
        tick(5);

        // Reset in the middle of WAIT drops the completion
        do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D);
        tick(2);
        rst_n = 1'b0;
        q1.delete();
        #1;
        chk("midrst_addr_ok", 32'(addr_ok[1]), 32'h0);
        chk("midrst_data_ok", 32'(data_ok[1]), 32'h0);
        chk("midrst_rdata", rdata[1], 32'h0);
        tick(2);
        rst_n = 1'b1;
        #1;
        chk("after_rst_addr_ok", 32'(addr_ok[1]), 32'h1);
        tick(6);
        do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            tick(1);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d/%0d completions outstanding, expected 0",
                     q0.size(), q1.size());
        end
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
